// File: rtl/mvd_can_mv_wr_pkg.sv
// Shared definitions for the MV candidate write side and its read-side companion.
// Contents:
// - picture column width
// - cell-address packing {y,x}
// - valid codes
// - FSM state type
// - a helper that clips a PU extent to the last cell index

`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 7
`endif

package mvd_can_mv_wr_pkg;

    localparam int unsigned PIC_X_W = `PIC_X_WIDTH;
    localparam int unsigned DATA_W  = 26;
    localparam int unsigned CELL_AW = 6;

    // Valid codes the read side uses to pick a buffer.
    typedef enum logic [1:0] {
        VldNone = 2'b00,
        VldNbr  = 2'b01,
        VldCur  = 2'b10
    } mv_vld_e;

    typedef enum logic [1:0] {
        StIdle,
        StPuWr,
        StCopy,
        StDone
    } state_e;

    function automatic logic [CELL_AW-1:0] cell_addr(input logic [2:0] y, input logic [2:0] x);
        return {y, x};
    endfunction

    // Last cell index covered by a PU dimension.
    // A sub-8 size still covers one cell.
    // Anything past cell 7 is clipped.
    function automatic logic [2:0] cell_last(input logic [2:0] first, input logic [3:0] ncells);
        logic [3:0] n;
        logic [4:0] last;
        n    = (ncells == 4'd0) ? 4'd1 : ncells;
        last = {2'b00, first} + {1'b0, n} - 5'd1;
        return (last > 5'd7) ? 3'd7 : last[2:0];
    endfunction

endpackage

// File: rtl/mvd_can_mv_wr_if.sv
// Command and memory-port bundle of mvd_can_mv_wr.
// master: the controller/bench side (drives PU commands and the current-array read data).
// slave : the write engine (drives busy/done and all memory write/read ports).

interface mvd_can_mv_wr_if;
    import mvd_can_mv_wr_pkg::*;

    logic [PIC_X_W-1:0]   mb_x_i;
    logic                 start_i;
    logic [5:0]           pos_x_i;
    logic [5:0]           pos_y_i;
    logic [6:0]           pu_width_i;
    logic [6:0]           pu_height_i;
    logic [DATA_W-1:0]    data_i;
    logic                 lcu_end_i;

    logic                 busy_o;
    logic                 pu_done_o;
    logic                 lcu_done_o;

    logic                 cur_wen_o;
    logic [CELL_AW-1:0]   cur_waddr_o;
    logic [DATA_W-1:0]    cur_wdata_o;
    logic                 cur_ren_o;
    logic [CELL_AW-1:0]   cur_raddr_o;
    logic [DATA_W-1:0]    cur_rdata_i;

    logic                 left_wen_o;
    logic [2:0]           left_addr_o;
    logic [DATA_W-1:0]    left_data_o;
    logic                 top_wen_o;
    logic [PIC_X_W+2:0]   top_addr_o;
    logic [DATA_W-1:0]    top_data_o;

    modport master (
        output mb_x_i, start_i, pos_x_i, pos_y_i, pu_width_i, pu_height_i, data_i, lcu_end_i,
        output cur_rdata_i,
        input  busy_o, pu_done_o, lcu_done_o,
        input  cur_wen_o, cur_waddr_o, cur_wdata_o, cur_ren_o, cur_raddr_o,
        input  left_wen_o, left_addr_o, left_data_o, top_wen_o, top_addr_o, top_data_o
    );

    modport slave (
        input  mb_x_i, start_i, pos_x_i, pos_y_i, pu_width_i, pu_height_i, data_i, lcu_end_i,
        input  cur_rdata_i,
        output busy_o, pu_done_o, lcu_done_o,
        output cur_wen_o, cur_waddr_o, cur_wdata_o, cur_ren_o, cur_raddr_o,
        output left_wen_o, left_addr_o, left_data_o, top_wen_o, top_addr_o, top_data_o
    );

endinterface

// File: rtl/mvd_can_mv_wr.sv
// Write side of the MV candidate store.
// - Writes each PU's motion data into the 8x8-cell current-LCU array, one cell per cycle.
// - At LCU end, copies column 7 into the left buffer and row 7 into the top-line buffer.
// Ports:
// - clk, rst : clock; synchronous active-high reset
// - bus      : slave side of mvd_can_mv_wr_if (commands, status, cur/left/top memory ports)

module mvd_can_mv_wr
    import mvd_can_mv_wr_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mvd_can_mv_wr_if.slave bus
);

    state_e              state_q, state_d;
    logic [2:0]          x_q, x_d;
    logic [2:0]          y_q, y_d;
    logic [2:0]          x0_q, x0_d;
    logic [2:0]          x_last_q, x_last_d;
    logic [2:0]          y_last_q, y_last_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [PIC_X_W-1:0]  mb_x_q, mb_x_d;
    logic                pend_q, pend_d;
    logic                copy_q, copy_d;     // current DONE belongs to a border copy
    logic [4:0]          k_q, k_d;           // copy read index, 16 = drain cycle
    logic                wr_vld_q, wr_vld_d; // border write pending from last cycle's read
    logic [3:0]          wr_k_q, wr_k_d;

    logic                cur_wen, cur_ren, pu_done, lcu_done;
    logic [CELL_AW-1:0]  cur_waddr, cur_raddr;
    logic [DATA_W-1:0]   cur_wdata;
    logic                left_wen, top_wen;

    logic unused_low_bits;
    assign unused_low_bits = ^{bus.pos_x_i[2:0], bus.pos_y_i[2:0],
                               bus.pu_width_i[2:0], bus.pu_height_i[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            x0_q     <= '0;
            x_last_q <= '0;
            y_last_q <= '0;
            data_q   <= '0;
            mb_x_q   <= '0;
            pend_q   <= 1'b0;
            copy_q   <= 1'b0;
            k_q      <= '0;
            wr_vld_q <= 1'b0;
            wr_k_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            x0_q     <= x0_d;
            x_last_q <= x_last_d;
            y_last_q <= y_last_d;
            data_q   <= data_d;
            mb_x_q   <= mb_x_d;
            pend_q   <= pend_d;
            copy_q   <= copy_d;
            k_q      <= k_d;
            wr_vld_q <= wr_vld_d;
            wr_k_q   <= wr_k_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        x0_d      = x0_q;
        x_last_d  = x_last_q;
        y_last_d  = y_last_q;
        data_d    = data_q;
        mb_x_d    = mb_x_q;
        pend_d    = pend_q;
        copy_d    = copy_q;
        k_d       = k_q;
        wr_vld_d  = 1'b0;
        wr_k_d    = wr_k_q;
        cur_wen   = 1'b0;
        cur_waddr = '0;
        cur_wdata = '0;
        cur_ren   = 1'b0;
        cur_raddr = '0;
        pu_done   = 1'b0;
        lcu_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    x0_d     = bus.pos_x_i[5:3];
                    x_d      = bus.pos_x_i[5:3];
                    y_d      = bus.pos_y_i[5:3];
                    x_last_d = cell_last(bus.pos_x_i[5:3], bus.pu_width_i[6:3]);
                    y_last_d = cell_last(bus.pos_y_i[5:3], bus.pu_height_i[6:3]);
                    data_d   = bus.data_i;
                    copy_d   = 1'b0;
                    state_d  = StPuWr;
                    // A simultaneous LCU end is deferred until this PU completes.
                    if (bus.lcu_end_i) begin
                        pend_d = 1'b1;
                        mb_x_d = bus.mb_x_i;
                    end
                end else if (bus.lcu_end_i) begin
                    mb_x_d  = bus.mb_x_i;
                    k_d     = '0;
                    copy_d  = 1'b1;
                    state_d = StCopy;
                end
            end
            StPuWr: begin
                cur_wen   = 1'b1;
                cur_waddr = cell_addr(y_q, x_q);
                cur_wdata = data_q;
                if (x_q == x_last_q) begin
                    if (y_q == y_last_q) begin
                        state_d = StDone;
                    end else begin
                        x_d = x0_q;
                        y_d = y_q + 3'd1;
                    end
                end else begin
                    x_d = x_q + 3'd1;
                end
            end
            StCopy: begin
                if (!k_q[4]) begin
                    cur_ren   = 1'b1;
                    // k<8: column 7 for the left buffer; k>=8: row 7 for the top line.
                    cur_raddr = k_q[3] ? cell_addr(3'd7, k_q[2:0]) : cell_addr(k_q[2:0], 3'd7);
                    wr_vld_d  = 1'b1;
                    wr_k_d    = k_q[3:0];
                    k_d       = k_q + 5'd1;
                end else begin
                    // Extra cycle lets the last read's write land before DONE.
                    state_d = StDone;
                end
            end
            StDone: begin
                pu_done  = ~copy_q;
                lcu_done = copy_q;
                if (pend_q) begin
                    pend_d  = 1'b0;
                    k_d     = '0;
                    copy_d  = 1'b1;
                    state_d = StCopy;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign left_wen = wr_vld_q & ~wr_k_q[3];
    assign top_wen  = wr_vld_q & wr_k_q[3];

    assign bus.busy_o      = (state_q != StIdle);
    assign bus.pu_done_o   = pu_done;
    assign bus.lcu_done_o  = lcu_done;
    assign bus.cur_wen_o   = cur_wen;
    assign bus.cur_waddr_o = cur_waddr;
    assign bus.cur_wdata_o = cur_wdata;
    assign bus.cur_ren_o   = cur_ren;
    assign bus.cur_raddr_o = cur_raddr;
    assign bus.left_wen_o  = left_wen;
    assign bus.left_addr_o = left_wen ? wr_k_q[2:0] : 3'd0;
    assign bus.left_data_o = left_wen ? bus.cur_rdata_i : '0;
    assign bus.top_wen_o   = top_wen;
    assign bus.top_addr_o  = top_wen ? {mb_x_q, wr_k_q[2:0]} : '0;
    assign bus.top_data_o  = top_wen ? bus.cur_rdata_i : '0;

endmodule
